// File: rtl/usb_pkg.sv
// usb_pkg: shared definitions for the handshake receiver.
//   - PID_* constants: 4-bit handshake packet identifiers
//   - hs_type_t: received handshake kind reported on hs_type
//   - err_t: failure cause reported on err_code
//   - state_t: receiver FSM states
//   - pid_check_ok(): PID byte self-check (upper nibble must be the inverse of the lower)
package usb_pkg;

  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;
  localparam logic [3:0] PID_NYET  = 4'b0110;

  typedef enum logic [1:0] {
    HS_ACK   = 2'd0,
    HS_NAK   = 2'd1,
    HS_STALL = 2'd2,
    HS_NYET  = 2'd3
  } hs_type_t;

  typedef enum logic [1:0] {
    ERR_TIMEOUT = 2'd0,
    ERR_PID_CHK = 2'd1,
    ERR_BAD_PID = 2'd2,
    ERR_BAD_EOP = 2'd3
  } err_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_SYNC = 3'd1,
    ST_READ_PID  = 3'd2,
    ST_WAIT_EOP  = 3'd3,
    ST_FINISH    = 3'd4
  } state_t;

  // The check field is the bitwise complement of the PID nibble.
  function automatic logic pid_check_ok(input logic [7:0] pid_byte);
    return (pid_byte[7:4] == ~pid_byte[3:0]);
  endfunction

endpackage

// File: rtl/pid_shift8.sv
// pid_shift8: 8-bit LSB-first shift register for the PID byte.
//   clk, rst_L : clock, asynchronous active-low reset
//   clr        : synchronous clear (new packet)
//   en         : shift one bit in (one decoded bit time)
//   bit_in     : serial data bit, first bit ends up in bit 0
//   byte_nxt   : byte value including the bit currently on bit_in, so the
//                caller can evaluate the full byte on the 8th shift itself
module pid_shift8 (
  input  logic       clk,
  input  logic       rst_L,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] byte_nxt
);

  logic [7:0] data_q;
  logic [7:0] data_d;

  // New bits enter at the MSB so after 8 shifts the first bit sits in bit 0.
  assign byte_nxt = {bit_in, data_q[7:1]};

  // Next shifter contents: clear has priority over shift.
  always_comb begin
    data_d = data_q;
    if (clr) begin
      data_d = 8'h00;
    end else if (en) begin
      data_d = byte_nxt;
    end else begin
      data_d = data_q;
    end
  end

  // Shifter register.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      data_q <= 8'h00;
    end else begin
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/rx_handshake.sv
// rx_handshake: receives one USB handshake packet (SYNC, PID, EOP) per start.
//   clk, rst_L : clock, asynchronous active-low reset
//   start      : request reception (accepted only when idle)
//   bit_valid  : one decoded bit time; everything advances only on it
//   bit_in     : destuffed data bit, LSB first
//   se0        : line is SE0 during this bit time
//   sync_ok    : sync detector matched (qualified by bit_valid)
//   en_sync_L  : active-low sync detector enable (low while hunting for sync)
//   busy       : reception in progress
//   done/fail  : one-cycle result pulses
//   hs_type    : handshake received (valid after done)
//   err_code   : failure cause (valid after fail)
module rx_handshake
  import usb_pkg::*;
#(
  parameter int TIMEOUT_BITS = 255,
  parameter int EOP_SE0_BITS = 2,
  parameter int ACCEPT_NYET  = 1
) (
  input  logic       clk,
  input  logic       rst_L,
  input  logic       start,
  input  logic       bit_valid,
  input  logic       bit_in,
  input  logic       se0,
  input  logic       sync_ok,
  output logic       en_sync_L,
  output logic       busy,
  output logic       done,
  output logic [1:0] hs_type,
  output logic       fail,
  output logic [1:0] err_code
);

  localparam int              TW       = $clog2(TIMEOUT_BITS + 1);
  localparam logic [TW-1:0]   TO_LAST  = TW'(TIMEOUT_BITS - 1);
  localparam logic [TW-1:0]   TO_SAT   = TW'(TIMEOUT_BITS);
  localparam logic [1:0]      EOP_LAST = 2'(EOP_SE0_BITS - 1);

  state_t        state_q, state_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [1:0]    eop_cnt_q, eop_cnt_d;
  hs_type_t      hs_q, hs_d;
  err_t          err_q, err_d;
  logic          done_q, done_d;
  logic          fail_q, fail_d;
  logic          busy_q, busy_d;
  logic          en_sync_L_q, en_sync_L_d;

  logic          shift_clr;
  logic          shift_en;
  logic [7:0]    byte_nxt;
  logic          pid_ok;
  hs_type_t      pid_hs;

  pid_shift8 u_shift (
    .clk      (clk),
    .rst_L    (rst_L),
    .clr      (shift_clr),
    .en       (shift_en),
    .bit_in   (bit_in),
    .byte_nxt (byte_nxt)
  );

  // Decode the PID nibble of the byte being completed into a handshake kind.
  always_comb begin
    pid_ok = 1'b0;
    pid_hs = HS_ACK;
    case (byte_nxt[3:0])
      PID_ACK:   begin pid_ok = 1'b1; pid_hs = HS_ACK;   end
      PID_NAK:   begin pid_ok = 1'b1; pid_hs = HS_NAK;   end
      PID_STALL: begin pid_ok = 1'b1; pid_hs = HS_STALL; end
      PID_NYET:  begin pid_ok = (ACCEPT_NYET != 0); pid_hs = HS_NYET; end
      default:   begin pid_ok = 1'b0; pid_hs = HS_ACK;   end
    endcase
  end

  // Next-state, counter and result logic.
  always_comb begin
    state_d   = state_q;
    to_cnt_d  = to_cnt_q;
    bit_cnt_d = bit_cnt_q;
    eop_cnt_d = eop_cnt_q;
    hs_d      = hs_q;
    err_d     = err_q;
    done_d    = 1'b0;
    fail_d    = 1'b0;
    shift_clr = 1'b0;
    shift_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_WAIT_SYNC;
          to_cnt_d  = '0;
          bit_cnt_d = 3'd0;
          eop_cnt_d = 2'd0;
          hs_d      = HS_ACK;
          err_d     = ERR_TIMEOUT;
          shift_clr = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_SYNC: begin
        if (bit_valid) begin
          if (to_cnt_q != TO_SAT) begin
            to_cnt_d = to_cnt_q + TW'(1'b1);
          end else begin
            to_cnt_d = to_cnt_q;
          end
          // A sync match on the last allowed bit still counts as found.
          if (sync_ok) begin
            state_d = ST_READ_PID;
          end else if (to_cnt_q >= TO_LAST) begin
            state_d = ST_FINISH;
            fail_d  = 1'b1;
            err_d   = ERR_TIMEOUT;
          end else begin
            state_d = ST_WAIT_SYNC;
          end
        end else begin
          state_d = ST_WAIT_SYNC;
        end
      end
      ST_READ_PID: begin
        if (bit_valid) begin
          if (se0) begin
            state_d = ST_FINISH;
            fail_d  = 1'b1;
            err_d   = ERR_BAD_EOP;
          end else begin
            shift_en  = 1'b1;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (!pid_check_ok(byte_nxt)) begin
                state_d = ST_FINISH;
                fail_d  = 1'b1;
                err_d   = ERR_PID_CHK;
              end else if (pid_ok) begin
                state_d = ST_WAIT_EOP;
                hs_d    = pid_hs;
              end else begin
                state_d = ST_FINISH;
                fail_d  = 1'b1;
                err_d   = ERR_BAD_PID;
              end
            end else begin
              state_d = ST_READ_PID;
            end
          end
        end else begin
          state_d = ST_READ_PID;
        end
      end
      ST_WAIT_EOP: begin
        if (bit_valid) begin
          if (!se0) begin
            state_d = ST_FINISH;
            fail_d  = 1'b1;
            err_d   = ERR_BAD_EOP;
          end else if (eop_cnt_q == EOP_LAST) begin
            state_d = ST_FINISH;
            done_d  = 1'b1;
          end else begin
            eop_cnt_d = eop_cnt_q + 2'd1;
          end
        end else begin
          state_d = ST_WAIT_EOP;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d      = (state_d != ST_IDLE);
    en_sync_L_d = (state_d != ST_WAIT_SYNC);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q     <= ST_IDLE;
      to_cnt_q    <= '0;
      bit_cnt_q   <= 3'd0;
      eop_cnt_q   <= 2'd0;
      hs_q        <= HS_ACK;
      err_q       <= ERR_TIMEOUT;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      busy_q      <= 1'b0;
      en_sync_L_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      eop_cnt_q   <= eop_cnt_d;
      hs_q        <= hs_d;
      err_q       <= err_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      busy_q      <= busy_d;
      en_sync_L_q <= en_sync_L_d;
    end
  end

  assign en_sync_L = en_sync_L_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fail      = fail_q;
  assign hs_type   = hs_q;
  assign err_code  = err_q;

endmodule

// File: tb/tb_rx_handshake.sv
// Bench for rx_handshake: two instances share the inputs, one with default
// parameters and one with TIMEOUT_BITS=6, EOP_SE0_BITS=3, ACCEPT_NYET=0.
// A packet-level model walks the bit list and predicts, per instance, the
// result and the clock edge at which the result pulse appears.
module tb_rx_handshake;

  logic clk = 1'b0;
  logic rst_L, start, bit_valid, bit_in, se0, sync_ok;
  logic       en_sync_L_w [2];
  logic       busy_w [2];
  logic       done_w [2];
  logic       fail_w [2];
  logic [1:0] hs_w [2];
  logic [1:0] err_w [2];

  int checks = 0;
  int errors = 0;

  int t_p  [2] = '{255, 6};
  int e_p  [2] = '{2, 3};
  int ny_p [2] = '{1, 0};

  bit q_sync [$];
  bit q_bit  [$];
  bit q_se0  [$];
  int q_gap  [$];
  int obs_e  [2];

  always #5 clk = ~clk;

  rx_handshake dut_a (
    .clk(clk), .rst_L(rst_L), .start(start), .bit_valid(bit_valid),
    .bit_in(bit_in), .se0(se0), .sync_ok(sync_ok),
    .en_sync_L(en_sync_L_w[0]), .busy(busy_w[0]), .done(done_w[0]),
    .hs_type(hs_w[0]), .fail(fail_w[0]), .err_code(err_w[0])
  );

  rx_handshake #(.TIMEOUT_BITS(6), .EOP_SE0_BITS(3), .ACCEPT_NYET(0)) dut_b (
    .clk(clk), .rst_L(rst_L), .start(start), .bit_valid(bit_valid),
    .bit_in(bit_in), .se0(se0), .sync_ok(sync_ok),
    .en_sync_L(en_sync_L_w[1]), .busy(busy_w[1]), .done(done_w[1]),
    .hs_type(hs_w[1]), .fail(fail_w[1]), .err_code(err_w[1])
  );

  task automatic clear_stim();
    q_sync.delete(); q_bit.delete(); q_se0.delete(); q_gap.delete();
  endtask

  task automatic push_bit(input bit s, input bit b, input bit e);
    q_sync.push_back(s); q_bit.push_back(b); q_se0.push_back(e); q_gap.push_back(0);
  endtask

  task automatic push_noise(input int n);
    for (int i = 0; i < n; i++) push_bit(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic push_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) push_bit(1'b0, v[i], 1'b0);
  endtask

  task automatic push_se0(input int n);
    for (int i = 0; i < n; i++) push_bit(1'b0, 1'b0, 1'b1);
  endtask

  task automatic push_tail();
    for (int i = 0; i < 3; i++) push_bit(1'b0, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic add_gaps();
    for (int i = 0; i < q_gap.size(); i++) q_gap[i] = $urandom_range(0, 2);
  endtask

  // Packet model: kind 0 = no result, 1 = done (code = hs), 2 = fail (code = err).
  // L = index of the bit that produced the result, S = index of the sync bit.
  task automatic model_run(input int tb_bits, input int eop_bits, input int ny,
                           output int kind, output int code, output int L, output int S);
    int n, i, k, c;
    logic [7:0] by;
    logic [3:0] p;
    n = q_sync.size(); i = 0; k = 0; c = 0; by = 8'h00;
    kind = 0; code = 0; L = -1; S = -1;
    while (i < n && S < 0 && kind == 0) begin
      k++;
      if (q_sync[i]) S = i;
      else if (k == tb_bits) begin kind = 2; code = 0; L = i; end
      i++;
    end
    if (kind != 0 || S < 0) return;
    for (int m = 0; m < 8; m++) begin
      if (i >= n) return;
      if (q_se0[i]) begin kind = 2; code = 3; L = i; return; end
      by[m] = q_bit[i];
      i++;
    end
    L = i - 1;
    p = by[3:0];
    if (by[7:4] != ~p) begin kind = 2; code = 1; return; end
    if (p == 4'b0010) code = 0;
    else if (p == 4'b1010) code = 1;
    else if (p == 4'b1110) code = 2;
    else if (p == 4'b0110 && ny != 0) code = 3;
    else begin kind = 2; code = 2; return; end
    while (i < n) begin
      if (q_se0[i]) begin
        c++;
        if (c == eop_bits) begin kind = 1; L = i; return; end
      end else begin
        kind = 2; code = 3; L = i; return;
      end
      i++;
    end
  endtask

  // Drive the queued packet (start edge 0, then bits with their gaps) and
  // check every instance output after every clock edge.
  task automatic run_pkt(input string name, input bit start_junk);
    int n, ei, bi, last, min_e;
    int eof [$];
    int kind [2]; int code [2]; int L [2]; int S [2]; int eL [2]; int eW [2];
    bit x_done, x_fail, x_busy, x_ens;
    n = q_sync.size();
    ei = 0;
    for (int i = 0; i < n; i++) begin
      ei = ei + 1 + q_gap[i];
      eof.push_back(ei);
    end
    for (int d = 0; d < 2; d++) begin
      model_run(t_p[d], e_p[d], ny_p[d], kind[d], code[d], L[d], S[d]);
      eL[d] = (kind[d] != 0) ? eof[L[d]] : 32'h3fffffff;
      eW[d] = (S[d] >= 0) ? eof[S[d]] : eL[d];
      obs_e[d] = -1;
    end
    min_e = (eL[0] < eL[1]) ? eL[0] : eL[1];
    last = eof[n-1] + 3;
    bi = 0;
    for (int e = 0; e <= last; e++) begin
      if (e == 0) begin
        start = 1'b1; bit_valid = 1'b0;
        sync_ok = 1'($urandom_range(0, 1)); bit_in = 1'($urandom_range(0, 1)); se0 = 1'($urandom_range(0, 1));
      end else begin
        start = (start_junk && e < min_e) ? 1'($urandom_range(0, 1)) : 1'b0;
        if (bi < n && e == eof[bi]) begin
          bit_valid = 1'b1; sync_ok = q_sync[bi]; bit_in = q_bit[bi]; se0 = q_se0[bi];
          bi++;
        end else begin
          bit_valid = 1'b0;
          sync_ok = 1'($urandom_range(0, 1)); bit_in = 1'($urandom_range(0, 1)); se0 = 1'($urandom_range(0, 1));
        end
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        x_done = (kind[d] == 1) && (e == eL[d]);
        x_fail = (kind[d] == 2) && (e == eL[d]);
        x_busy = (e <= eL[d]);
        x_ens  = !(e < eW[d]);
        if ((done_w[d] === 1'b1 || fail_w[d] === 1'b1) && obs_e[d] < 0) obs_e[d] = e;
        checks += 4;
        if (done_w[d] !== x_done) begin
          errors++; $display("FAIL %s dut%0d edge %0d done got %b exp %b", name, d, e, done_w[d], x_done);
        end
        if (fail_w[d] !== x_fail) begin
          errors++; $display("FAIL %s dut%0d edge %0d fail got %b exp %b", name, d, e, fail_w[d], x_fail);
        end
        if (busy_w[d] !== x_busy) begin
          errors++; $display("FAIL %s dut%0d edge %0d busy got %b exp %b", name, d, e, busy_w[d], x_busy);
        end
        if (en_sync_L_w[d] !== x_ens) begin
          errors++; $display("FAIL %s dut%0d edge %0d en_sync_L got %b exp %b", name, d, e, en_sync_L_w[d], x_ens);
        end
        if (e == eL[d] || e == last) begin
          checks++;
          if (kind[d] == 1 && hs_w[d] !== 2'(code[d])) begin
            errors++; $display("FAIL %s dut%0d edge %0d hs_type got %0d exp %0d", name, d, e, hs_w[d], code[d]);
          end else if (kind[d] == 2 && err_w[d] !== 2'(code[d])) begin
            errors++; $display("FAIL %s dut%0d edge %0d err_code got %0d exp %0d", name, d, e, err_w[d], code[d]);
          end
        end
      end
    end
    start = 1'b0; bit_valid = 1'b0; sync_ok = 1'b0; se0 = 1'b0; bit_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_L = 1'b0; start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; se0 = 1'b0; sync_ok = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({en_sync_L_w[d], busy_w[d], done_w[d], fail_w[d], hs_w[d], err_w[d]} !== 8'b1000_0000) begin
        errors++;
        $display("FAIL reset dut%0d en_sync_L/busy/done/fail/hs/err got %b%b%b%b %0d %0d exp 1000 0 0",
                 d, en_sync_L_w[d], busy_w[d], done_w[d], fail_w[d], hs_w[d], err_w[d]);
      end
    end
    @(negedge clk);
    rst_L = 1'b1;
  endtask

  task automatic test_ack();
    clear_stim(); push_noise(4); push_bit(1'b1, 1'b0, 1'b0); push_byte(8'hD2); push_se0(2); push_tail();
    run_pkt("ack", 1'b0);
    checks++;
    if (obs_e[0] !== 15) begin
      errors++; $display("FAIL ack_latency dut0 pulse edge got %0d exp 15", obs_e[0]);
    end
  endtask

  task automatic test_timeout();
    clear_stim(); push_noise(256);
    run_pkt("timeout", 1'b0);
    clear_stim(); push_noise(254); push_bit(1'b1, 1'b0, 1'b0); push_byte(8'hD2); push_se0(2); push_tail();
    run_pkt("sync_on_last", 1'b0);
    clear_stim(); push_noise(5); push_bit(1'b1, 1'b0, 1'b0); push_byte(8'h5A); push_se0(3); push_tail();
    run_pkt("sync_on_last_b", 1'b0);
  endtask

  task automatic test_pid();
    logic [7:0] bytes [5] = '{8'hF2, 8'hF0, 8'h96, 8'h5A, 8'h1E};
    for (int i = 0; i < 5; i++) begin
      clear_stim(); push_noise(2); push_bit(1'b1, 1'b0, 1'b0); push_byte(bytes[i]); push_se0(3); push_tail();
      run_pkt("pid", 1'b0);
    end
  endtask

  task automatic test_bad_eop();
    for (int g = 0; g < 2; g++) begin
      clear_stim(); push_noise(1); push_bit(1'b1, 1'b0, 1'b0); push_byte(8'h5A); push_tail();
      if (g == 1) add_gaps();
      run_pkt(g == 0 ? "bad_eop" : "bad_eop_gaps", 1'b0);
    end
    clear_stim(); push_bit(1'b1, 1'b0, 1'b0); push_byte(8'hD2); q_se0[4] = 1'b1; push_se0(2); push_tail();
    run_pkt("se0_in_pid", 1'b0);
  endtask

  task automatic test_start_ignored();
    clear_stim(); push_noise(3); push_bit(1'b1, 1'b0, 1'b0); push_byte(8'hD2); push_se0(2); push_tail();
    add_gaps();
    run_pkt("start_busy", 1'b1);
  endtask

  task automatic test_reset_mid();
    start = 1'b1; bit_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; bit_valid = 1'b1; sync_ok = 1'b1; bit_in = 1'b0; se0 = 1'b0;
    @(posedge clk); #1;
    sync_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bit_in = (i == 1); @(posedge clk); #1;
    end
    #2 rst_L = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({busy_w[d], done_w[d], fail_w[d], en_sync_L_w[d]} !== 4'b0001) begin
        errors++; $display("FAIL reset_mid dut%0d busy/done/fail/en_sync_L got %b%b%b%b exp 0001",
                           d, busy_w[d], done_w[d], fail_w[d], en_sync_L_w[d]);
      end
    end
    repeat (2) @(negedge clk);
    rst_L = 1'b1;
    for (int c = 0; c < 12; c++) begin
      bit_in = 1'($urandom_range(0, 1)); se0 = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({busy_w[d], done_w[d], fail_w[d]} !== 3'b000) begin
          errors++; $display("FAIL reset_mid_after dut%0d busy/done/fail got %b%b%b exp 000",
                             d, busy_w[d], done_w[d], fail_w[d]);
        end
      end
    end
    bit_valid = 1'b0; se0 = 1'b0;
  endtask

  task automatic test_random();
    logic [3:0] pids [4] = '{4'b0010, 4'b1010, 4'b1110, 4'b0110};
    logic [3:0] p;
    logic [7:0] by;
    int r;
    for (int it = 0; it < 25; it++) begin
      clear_stim();
      push_noise($urandom_range(0, 8));
      push_bit(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      r = $urandom_range(0, 5);
      p = pids[$urandom_range(0, 3)];
      if (r <= 3) by = {~p, p};
      else if (r == 4) by = 8'($urandom_range(0, 255));
      else by = {~p, p} ^ (8'h01 << $urandom_range(0, 7));
      push_byte(by);
      if ($urandom_range(0, 5) == 0) q_se0[q_se0.size() - 1 - $urandom_range(0, 7)] = 1'b1;
      push_se0($urandom_range(0, 3));
      push_tail();
      if ($urandom_range(0, 1) == 1) add_gaps();
      run_pkt("random", 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_ack();
    test_timeout();
    test_pid();
    test_bad_eop();
    test_start_ignored();
    test_reset_mid();
    test_ack();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_handshake.md
RX_HANDSHAKE -- requirements
Module: rx_handshake

Interface
REQ-001 SHALL have parameter TIMEOUT_BITS, default 255, meaning bit times allowed in WAIT_SYNC before timeout (legal range 2..1023).
REQ-002 SHALL have parameter EOP_SE0_BITS, default 2, meaning consecutive SE0 bit times required for EOP (legal range 1..3).
REQ-003 SHALL have parameter ACCEPT_NYET, default 1, meaning NYET is accepted as a handshake; 0 means NYET is rejected as bad PID.
REQ-004 SHALL have port clk, input, 1, system clock.
REQ-005 SHALL have port rst_L, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, pulse requesting reception of one handshake packet.
REQ-007 SHALL have port bit_valid, input, 1, strobe marking one decoded bit time; all counters and the shifter advance only on bit_valid.
REQ-008 SHALL have port bit_in, input, 1, destuffed NRZI-decoded data bit, LSB first.
REQ-009 SHALL have port se0, input, 1, line in SE0 during this bit time.
REQ-010 SHALL have port sync_ok, input, 1, sync detector has matched, qualified by bit_valid.
REQ-011 SHALL have port en_sync_L, output, 1, active-low sync detector enable.
REQ-012 SHALL have port busy, output, 1, packet reception in progress.
REQ-013 SHALL have port done, output, 1, one-cycle pulse marking a valid handshake received.
REQ-014 SHALL have port hs_type, output, 2, received handshake: ACK/NAK/STALL/NYET.
REQ-015 SHALL have port fail, output, 1, one-cycle pulse marking reception failure.
REQ-016 SHALL have port err_code, output, 2, failure cause: TIMEOUT/PID_CHK/BAD_PID/BAD_EOP.

Function
REQ-017 SHALL implement states IDLE, WAIT_SYNC, READ_PID, WAIT_EOP, FINISH.
REQ-018 IDLE: start -> WAIT_SYNC and clear all counters; start SHALL be ignored in every other state.
REQ-019 WAIT_SYNC: en_sync_L=0; each bit_valid increments the timeout counter; bit_valid&sync_ok -> READ_PID.
REQ-020 WAIT_SYNC: the bit_valid that completes TIMEOUT_BITS bit times without sync_ok -> FINISH with err TIMEOUT; sync_ok on that same bit SHALL win.
REQ-021 READ_PID: shift 8 bits LSB first on bit_valid; after the 8th bit, evaluate byte[3:0]=PID and byte[7:4]=~PID.
REQ-022 A check-field mismatch SHALL give err PID_CHK (takes priority over BAD_PID) -> FINISH.
REQ-023 PID 0010=ACK, 1010=NAK, 1110=STALL, 0110=NYET (NYET only if ACCEPT_NYET=1); any other PID SHALL give err BAD_PID -> FINISH.
REQ-024 A valid PID SHALL latch hs_type and -> WAIT_EOP.
REQ-025 se0=1 on any bit during READ_PID SHALL give err BAD_EOP -> FINISH immediately.
REQ-026 WAIT_EOP: each bit_valid with se0=1 increments the EOP counter; se0=0 before EOP_SE0_BITS reached SHALL give err BAD_EOP.
REQ-027 WAIT_EOP: the bit_valid reaching EOP_SE0_BITS SHALL -> FINISH with success.
REQ-028 FINISH lasts one cycle, asserts exactly one of done or fail, then -> IDLE.
REQ-029 err_code and hs_type SHALL hold their last values until the next accepted start; hs_type is meaningful only after done.
REQ-030 busy SHALL be 1 in WAIT_SYNC, READ_PID, WAIT_EOP, FINISH; 0 in IDLE.
REQ-031 Without bit_valid, state and counters SHALL hold, except that FINISH always exits.
REQ-032 The timeout counter SHALL be $clog2(TIMEOUT_BITS+1) bits and SHALL saturate, never wrap.

Reset
REQ-033 rst_L low SHALL asynchronously force IDLE and clear counters and shifter; outputs SHALL reset to en_sync_L=1, busy=0, done=0, fail=0, hs_type=ACK(0), err_code=TIMEOUT(0).
REQ-034 Reset mid-packet SHALL abort without a done or fail pulse.

Structure
REQ-035 usb_pkg SHALL hold the PID constants, the hs_type_t and err_t enums, and the state enum.
REQ-036 One sub-module, pid_shift8 (8-bit enable-gated LSB-first shifter), SHALL be instantiated; counters SHALL be inline.

Verification
REQ-038 start, sync_ok after 5 bits, PID byte 0xD2, two SE0 bits -> done=1 with hs_type=ACK, 5+8+2 bit_valids after start.
REQ-039 start, no sync_ok for 255 bit_valids -> fail=1, err_code=TIMEOUT; with sync_ok on bit 255 -> proceeds to READ_PID.
REQ-040 PID byte 0xF2 (bad check field) -> fail, err_code=PID_CHK; byte 0xF0 (PID 0000) -> fail, err_code=BAD_PID.
REQ-041 NYET byte 0x96 with ACCEPT_NYET=0 -> BAD_PID; with ACCEPT_NYET=1 -> done, hs_type=NYET.
REQ-042 Valid NAK then se0=0 on the 1st EOP bit -> fail, BAD_EOP; gaps in bit_valid during a packet -> identical result, delayed.
REQ-043 rst_L asserted in READ_PID -> IDLE, no pulse; a second start while busy -> ignored.
